mem_arbiter: RTL
================

# mem_arbiter

Three-port arbiter sharing the single LPDDR memory-controller user port between the video fetcher, the disk (MMC) DMA engine and the CPU bus in `top_niox`. It serialises word transactions, gives video strict priority and round-robins between disk and CPU. It presents a one-transaction-at-a-time request/done interface to the memory controller and a request/ack pulse interface to each requester.

## Interface
Parameters:
- `AW`, 22: word address width.
- `DW`, 32: data width.
- `TIMEOUT`, 1023: watchdog limit in cycles. Only used with `MEM_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock for the block and all requesters.
- `reset`  in  1  synchronous, active-high.
- `req`  in  3  per-port request. Index 0 = video, 1 = disk, 2 = cpu.
- `wr`  in  3  per-port write flag (1 = write).
- `addr`  in  3*AW  per-port address. Port i occupies `[i*AW +: AW]`.
- `wdata`  in  3*DW  per-port write data. Port i occupies `[i*DW +: DW]`.
- `ack`  out  3  one-cycle completion pulse to the granted port.
- `rdata`  out  DW  read data, valid in the `ack` cycle.
- `err`  out  1  transaction aborted, valid in the `ack` cycle.
- `mem_req`  out  1  one-cycle command strobe to the memory controller.
- `mem_wr`  out  1  command is a write.
- `mem_addr`  out  AW  command address.
- `mem_wdata`  out  DW  command write data.
- `mem_done`  in  1  one-cycle completion from the memory controller.
- `mem_rdata`  in  DW  read data, valid with `mem_done`.

## Operation
- FSM states:
  - IDLE: if any `req` is high, latch the winner's index, `wr`, `addr` and `wdata`, then go to ISSUE.
  - ISSUE: `mem_req`=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold until `mem_done`, then go to ACK. On `mem_done`, register `mem_rdata` into `rdata`.
  - ACK: `ack[g]`=1 for one cycle, then go to IDLE.
- Arbitration, evaluated only in IDLE:
  - `req[0]` wins unconditionally.
  - Otherwise, if both `req[1]` and `req[2]` are high, the port not served most recently among {1,2} wins.
  - A `last_rr` bit updates only when port 1 or 2 is granted. Reset value: port 2 last, so disk wins the first tie.
- Requesters hold `req`, `wr`, `addr` and `wdata` stable until `ack`. The block ignores changes to them after the IDLE sample.
- A `req` still high in the cycle after `ack` is a new transaction.
- Dropping `req` before `ack` is illegal. The transaction still completes and `ack` still pulses.
- `mem_addr`, `mem_wr` and `mem_wdata` are driven from the latched registers and held stable from ISSUE through ACK.
- `rdata` is undefined for writes. It retains its last value and is not cleared.
- `mem_done` outside WAIT is ignored.
- Reset values: `ack`=0, `mem_req`=0, `err`=0, `rdata`=0, `mem_addr`=0, `mem_wr`=0, `mem_wdata`=0, state IDLE, `last_rr`=2.
- Reset mid-transaction:
  - Return to IDLE immediately and issue no `ack`.
  - The memory controller is reset by the same `reset`, so an outstanding command is abandoned.

## Timing
- Request sampled in IDLE at cycle 0 → `mem_req` at cycle 1.
- `mem_done` is legal from cycle 2 onward.
- `mem_done` in cycle N → `ack` in cycle N+1.
- Minimum latency from `req` to `ack` is 3 cycles.
- Back-to-back: the next IDLE sample is at cycle N+2, so the minimum issue rate is one transaction per 4 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A WAIT-cycle counter is cleared on entry to ISSUE.
  - If it reaches `TIMEOUT` without `mem_done`, go to ACK with `err`=1 and `rdata`=32'hDEADBEEF (truncated or zero-extended to DW).
  - `mem_done` arriving in the same cycle as expiry wins, giving a normal completion with `err`=0.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - No counter; WAIT is unbounded.
  - `err` is tied to 0.

## Structure
- Package `mem_arb_pkg` holds:
  - Port index constants `PORT_VID`=0, `PORT_DSK`=1, `PORT_CPU`=2.
  - The state enum (IDLE, ISSUE, WAIT, ACK).
  - The `DEADBEEF` abort pattern.
- Sub-module `mem_arb_pick` is purely combinational. Inputs: `req[2:0]` and `last_rr`. Output: the one-hot grant. It is kept separate so it can be unit-tested exhaustively.

## Test plan
- Single CPU read at addr 22'h000123, memory model `mem_done` at cycle 4 with rdata 32'h12345678 → `mem_req` at cycle 1 with `mem_addr`=22'h000123 and `mem_wr`=0; `ack[2]` at cycle 5 with `rdata`=32'h12345678.
- All three `req` high from cycle 0, held until each port's ack → `ack` order is 0, 1, 2; exactly 3 `mem_req` pulses; each latched address matches its port.
- Disk and CPU both continuously requesting for 6 transactions → grants alternate 1, 2, 1, 2, 1, 2. Video asserting mid-stream preempts at the next IDLE sample only.
- Disk write with `wdata`=32'hCAFEF00D → `mem_wr`=1 and `mem_wdata`=32'hCAFEF00D, both stable from ISSUE through ACK; `ack[1]` one cycle after `mem_done`.
- Assert `reset` for 1 cycle while in WAIT → next cycle all outputs are at reset values and no `ack` occurs; a `mem_done` arriving afterwards is ignored.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT`=16, a CPU read with no `mem_done` → `ack[2]` with `err`=1 and `rdata`=32'hDEADBEEF, 17 cycles after ISSUE. Without the macro, the same stimulus leaves the block in WAIT indefinitely with `err`=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and state type for the three-port memory arbiter.
package mem_arb_pkg;

    localparam int PORT_VID = 0;
    localparam int PORT_DSK = 1;
    localparam int PORT_CPU = 2;
    localparam int NPORTS   = 3;

    localparam logic [31:0] ABORT_PATTERN = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: video has strict priority, disk/cpu round-robin.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic       last_rr,
    output logic [2:0] gnt
);

    // last_rr = 1 means cpu was served most recently, so disk wins a tie
    always_comb begin
        gnt = '0;
        if (req[PORT_VID]) begin
            gnt[PORT_VID] = 1'b1;
        end else if (req[PORT_DSK] && (!req[PORT_CPU] || last_rr)) begin
            gnt[PORT_DSK] = 1'b1;
        end else if (req[PORT_CPU]) begin
            gnt[PORT_CPU] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises video/disk/cpu word transactions onto one memory-controller port.
// Optional WAIT watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | sample req, latch winner's command
// ISSUE | one-cycle mem_req strobe
// WAIT  | hold until mem_done (or watchdog expiry)
// ACK   | one-cycle ack pulse to the granted port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 22,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [2:0]        wr,
    input  logic [3*AW-1:0]   addr,
    input  logic [3*DW-1:0]   wdata,
    output logic [2:0]        ack,
    output logic [DW-1:0]     rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_done,
    input  logic [DW-1:0]     mem_rdata
);

    arb_state_e    state_q, state_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [2:0]    pick_gnt;
    logic          last_rr_q, last_rr_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [2:0]    ack_q, ack_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    mem_arb_pick u_pick (
        .req     (req),
        .last_rr (last_rr_q),
        .gnt     (pick_gnt)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_rr_d   = last_rr_q;
        mem_req_d   = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ack_d       = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d   = ISSUE;
                    gnt_d     = pick_gnt;
                    mem_req_d = 1'b1;
                    for (int i = 0; i < NPORTS; i++) begin
                        if (pick_gnt[i]) begin
                            mem_wr_d    = wr[i];
                            mem_addr_d  = addr[i*AW +: AW];
                            mem_wdata_d = wdata[i*DW +: DW];
                        end
                    end
                    if (pick_gnt[PORT_DSK] || pick_gnt[PORT_CPU]) begin
                        last_rr_d = pick_gnt[PORT_CPU];
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_done) begin
                    state_d = ACK;
                    rdata_d = mem_rdata;
                    ack_d   = gnt_q;
`ifdef MEM_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ACK;
                    rdata_d = DW'(ABORT_PATTERN);
                    ack_d   = gnt_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            last_rr_q   <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ack_q       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_rr_q   <= last_rr_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
